// File: rtl/module_bin_to_bcd_seq.sv
`timescale 1ns/1ps
// module_bin_to_bcd_seq
// Sequential binary-to-BCD converter (double-dabble, one input bit per clock).
// Sits between arithmetic/counter logic and the 7-segment display driver.
//
// Handshake: i_start is a request that is accepted only on an edge where the
// converter is idle (o_busy=0). The accepting edge captures i_bin; i_start and
// i_bin are ignored while o_busy=1. o_done is a one-cycle pulse marking the
// cycle in which o_bcd/o_overflow first show the new result; both hold until
// the next completion. No request queuing.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst_n     synchronous active-low reset
//   i_start     conversion request (sampled only when idle)
//   i_bin       unsigned binary operand, BIN_W bits
//   o_busy      high while a conversion is in progress
//   o_done      one-cycle completion pulse
//   o_bcd       result, digit 0 in [3:0], saturated to all 9s on overflow
//   o_overflow  last operand exceeded 10^DIGITS-1
//   o_state     debug view of the FSM state (0 idle, 1 shift, 2 done)
module module_bin_to_bcd_seq #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [BIN_W-1:0]      i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_overflow,
  output logic [1:0]            o_state
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [BIN_W-1:0]   sr_q;
  logic [BCD_W-1:0]   acc_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   acc_shift;
  logic [BIN_W-1:0]   sr_shift;
  logic               carry_out;

  assign o_state = state_q;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_start) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One double-dabble step: add 3 to every digit >= 5, then shift the whole
  // {accumulator, binary} chain left. A digit >= 5 becomes >= 8 after the add,
  // so the bit leaving the top digit means the value no longer fits in DIGITS
  // decimal digits; that bit feeds the sticky overflow flag.
  // ---------------------------------------------------------------------------
  always_comb begin
    adj = acc_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc_q[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
      end
    end
  end

  assign {carry_out, acc_shift, sr_shift} = {adj, sr_q, 1'b0};

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sr_q       <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_bcd      <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            sr_q    <= i_bin;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= CNT_W'(BIN_W);
            o_busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          acc_q   <= acc_shift;
          sr_q    <= sr_shift;
          carry_q <= carry_q | carry_out;
          cnt_q   <= cnt_q - CNT_W'(1);
        end
        ST_DONE: begin
          // On overflow the accumulator holds a wrapped value; saturate instead.
          o_bcd      <= carry_q ? {DIGITS{4'h9}} : acc_q;
          o_overflow <= carry_q;
          o_done     <= 1'b1;
          o_busy     <= 1'b0;
        end
        default: begin
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_module_bin_to_bcd_seq.sv
`timescale 1ns/1ps
module tb_module_bin_to_bcd_seq;

  localparam int BIN_W = 12;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic [BIN_W-1:0] bin = '0;

  // Two instances share stimulus: 4 digits (no overflow possible) and 3 digits.
  logic        busy4, done4, ovf4;
  logic [15:0] bcd4;
  logic [1:0]  st4;
  logic        busy3, done3, ovf3;
  logic [11:0] bcd3;
  logic [1:0]  st3;

  module_bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_bin(bin),
    .o_busy(busy4), .o_done(done4), .o_bcd(bcd4), .o_overflow(ovf4), .o_state(st4)
  );

  module_bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_bin(bin),
    .o_busy(busy3), .o_done(done3), .o_bcd(bcd3), .o_overflow(ovf3), .o_state(st3)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check helper
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: plain decimal arithmetic on the captured value
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] conv_bcd(input int v, input int digits);
    int max_v = 1;
    int t;
    logic [15:0] r = '0;
    for (int i = 0; i < digits; i++) max_v *= 10;
    if (v > max_v - 1) begin
      for (int i = 0; i < digits; i++) r[4*i +: 4] = 4'h9;
    end else begin
      t = v;
      for (int i = 0; i < digits; i++) begin
        r[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
    end
    return r;
  endfunction

  function automatic logic conv_ovf(input int v, input int digits);
    int max_v = 1;
    for (int i = 0; i < digits; i++) max_v *= 10;
    return v > max_v - 1;
  endfunction

  // Model: a conversion accepted on an idle edge completes BIN_W+1 edges later.
  int          m_rem = 0;
  int          m_val = 0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_ovf4 = 1'b0, m_ovf3 = 1'b0;
  logic [15:0] m_bcd4 = '0;
  logic [11:0] m_bcd3 = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_rem  <= 0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_bcd4 <= '0;
      m_ovf4 <= 1'b0;
      m_bcd3 <= '0;
      m_ovf3 <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_bcd4 <= conv_bcd(m_val, 4);
          m_ovf4 <= conv_ovf(m_val, 4);
          m_bcd3 <= 12'(conv_bcd(m_val, 3));
          m_ovf3 <= conv_ovf(m_val, 3);
        end
      end else if (start) begin
        m_val  <= int'(bin);
        m_rem  <= BIN_W + 1;
        m_busy <= 1'b1;
      end
    end
  end

  // Compare process: every cycle once reset has been applied.
  always @(negedge clk) begin
    if (chk_on) begin
      check("busy4", 32'(busy4), 32'(m_busy));
      check("done4", 32'(done4), 32'(m_done));
      check("bcd4",  32'(bcd4),  32'(m_bcd4));
      check("ovf4",  32'(ovf4),  32'(m_ovf4));
      check("busy3", 32'(busy3), 32'(m_busy));
      check("done3", 32'(done3), 32'(m_done));
      check("bcd3",  32'(bcd3),  32'(m_bcd3));
      check("ovf3",  32'(ovf3),  32'(m_ovf3));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic run_one(input int v, output int lat, output int busy_n);
    bin   = BIN_W'(v);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    lat    = -1;
    busy_n = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy4) busy_n++;
      if (done4) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int lat, busy_n, nd, last, exp_v;
    int vals2[5];
    logic [15:0] exp2[5];
    int vals5[4];
    logic [11:0] exp5_bcd[4];
    logic exp5_ovf[4];

    vals2 = '{0, 15, 255, 999, 4095};
    exp2  = '{16'h0000, 16'h0015, 16'h0255, 16'h0999, 16'h4095};
    vals5 = '{999, 1000, 4095, 7};
    exp5_bcd = '{12'h999, 12'h999, 12'h999, 12'h007};
    exp5_ovf = '{1'b0, 1'b1, 1'b1, 1'b0};

    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_bcd",  32'(bcd4),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single conversion: latency and busy width
    run_one(123, lat, busy_n);
    check("t1_latency", 32'(lat), 32'd13);
    check("t1_busy_cycles", 32'(busy_n), 32'd13);
    check("t1_bcd4", 32'(bcd4), 32'h0123);
    check("t1_ovf4", 32'(ovf4), 32'd0);

    // Value sweep
    for (int i = 0; i < 5; i++) begin
      run_one(vals2[i], lat, busy_n);
      check("t2_bcd4", 32'(bcd4), 32'(exp2[i]));
      check("t2_ovf4", 32'(ovf4), 32'd0);
    end

    // Start requests while busy are ignored
    bin = 12'd500; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      if (k == 3 || k == 12) begin
        start = 1'b1; bin = 12'd7;
      end else begin
        start = 1'b0;
      end
      if (done4) begin
        nd++;
        check("t3_bcd4", 32'(bcd4), 32'h0500);
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("t3_done_count", 32'(nd), 32'd1);

    // Start held high: back-to-back conversions every BIN_W+2 cycles
    bin = 12'd42; start = 1'b1;
    @(negedge clk);
    exp_v = 42; nd = 0; last = -1;
    for (int c = 0; c < 80; c++) begin
      if (done4) begin
        check("t4_bcd4", 32'(bcd4), (exp_v == 42) ? 32'h0042 : 32'h0043);
        if (last >= 0) check("t4_period", 32'(c - last), 32'd14);
        last  = c;
        nd++;
        exp_v = (exp_v == 42) ? 43 : 42;
        bin   = BIN_W'(exp_v);
        if (nd == 4) break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("t4_done_count", 32'(nd), 32'd4);
    repeat (16) @(negedge clk);

    // Three-digit instance: overflow boundaries
    for (int i = 0; i < 4; i++) begin
      run_one(vals5[i], lat, busy_n);
      check("t5_bcd3", 32'(bcd3), 32'(exp5_bcd[i]));
      check("t5_ovf3", 32'(ovf3), 32'(exp5_ovf[i]));
    end

    // Reset mid-conversion
    bin = 12'd321; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_busy", 32'(busy4), 32'd0);
    check("t6_bcd4", 32'(bcd4),  32'd0);
    check("t6_ovf3", 32'(ovf3),  32'd0);
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      if (done4 || done3) nd++;
      @(negedge clk);
    end
    check("t6_no_done", 32'(nd), 32'd0);
    run_one(321, lat, busy_n);
    check("t6_bcd4_after", 32'(bcd4), 32'h0321);

    // Randomized traffic, including boundary-heavy operands and rare resets
    for (int c = 0; c < 900; c++) begin
      start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0:       bin = 12'd999;
        1:       bin = 12'd1000;
        2:       bin = 12'hfff;
        default: bin = BIN_W'($urandom_range(0, 4095));
      endcase
      rst_n = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (20) @(negedge clk);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
